alu_multicycle_exec: RTL and testbench

- Execution-side consumer of the 4-bit ALU operation code produced by the ALU control decoder.
- Accepts one operation per start pulse and registers the result.
- Performs shifts iteratively, one bit per cycle, to save area versus a barrel shifter.
- Sits between the ALU control decoder/operand muxes and the writeback path of the multi-cycle datapath variant.

---
 rtl/alu_multicycle_exec.sv | 122 ++++++++++++
 tb/tb_alu_multicycle_exec.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle_exec.sv
// Multi-cycle ALU execute stage: single-cycle ADD/SUB/OR/LUI, iterative one-bit-per-cycle SRL/SLL.
// Optional macro ALU_BARREL_SHIFT_EN replaces the iterative shifter with a single-cycle barrel shift.
module alu_multicycle_exec #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   result, result_next;
    logic [SHAMT_WIDTH-1:0]  shamt;

    assign shamt = B_i[SHAMT_WIDTH-1:0];

`ifndef ALU_BARREL_SHIFT_EN
    // Only the shift direction of the latched opcode matters once the shift is running.
    logic [SHAMT_WIDTH-1:0]  count, count_next;
    logic                    shift_left, shift_left_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result     <= '0;
`ifndef ALU_BARREL_SHIFT_EN
            count      <= '0;
            shift_left <= 1'b0;
`endif
        end else begin
            result     <= result_next;
`ifndef ALU_BARREL_SHIFT_EN
            count      <= count_next;
            shift_left <= shift_left_next;
`endif
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a hold default first, so no path can infer a latch.
        state_next      = state;
        result_next     = result;
`ifndef ALU_BARREL_SHIFT_EN
        count_next      = count;
        shift_left_next = shift_left;
`endif
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = DONE;
                    case (ALU_Operation_i)
                        OP_ADD: result_next = A_i + B_i;
                        OP_SUB: result_next = A_i - B_i;
                        OP_OR:  result_next = A_i | B_i;
                        OP_LUI: result_next = B_i;
`ifdef ALU_BARREL_SHIFT_EN
                        OP_SRL: result_next = A_i >> shamt;
                        OP_SLL: result_next = A_i << shamt;
`else
                        OP_SRL, OP_SLL: begin
                            result_next     = A_i;
                            count_next      = shamt;
                            shift_left_next = (ALU_Operation_i == OP_SLL);
                            if (shamt != '0) begin
                                state_next = SHIFT;
                            end
                        end
`endif
                        default: result_next = '0;
                    endcase
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            SHIFT: begin
                result_next = shift_left ? (result << 1) : (result >> 1);
                count_next  = count - SHAMT_WIDTH'(1);
                if (count == SHAMT_WIDTH'(1)) begin
                    state_next = DONE;
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE);
    assign ALU_Result_o = result;
    assign Zero_o       = (result == '0);

endmodule

// File: tb/tb_alu_multicycle_exec.sv
// Self-checking bench for alu_multicycle_exec: directed vectors with literal expectations plus a
// transaction-level model (result and latency per accepted op) compared every cycle.
module tb_alu_multicycle_exec;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          start_i = 1'b0;
    logic [3:0]    op      = 4'b0000;
    logic [W-1:0]  a       = '0;
    logic [W-1:0]  b       = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  res;
    logic          zero;

    always #5 clk = ~clk;

    alu_multicycle_exec #(.DATA_WIDTH(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .ALU_Operation_i (op),
        .A_i             (a),
        .B_i             (b),
        .busy_o          (busy),
        .done_o          (done),
        .ALU_Result_o    (res),
        .Zero_o          (zero)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: what an accepted op must produce, and after how many cycles.
    function automatic logic [W-1:0] model_result(input logic [3:0] o, input logic [W-1:0] x,
                                                  input logic [W-1:0] y);
        int unsigned amt;
        amt = int'(y[SW-1:0]);
        case (o)
            4'b0000: return x + y;
            4'b0001: return x - y;
            4'b0011: return x | y;
            4'b0101: return y;
            4'b0110: return x >> amt;
            4'b0111: return x << amt;
            default: return '0;
        endcase
    endfunction

    function automatic int model_latency(input logic [3:0] o, input logic [W-1:0] y);
        int amt;
        amt = int'(y[SW-1:0]);
        if (o != 4'b0110 && o != 4'b0111) return 1;
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        return (amt == 0) ? 1 : amt + 1;
`endif
    endfunction

    int           edge_n   = 0;
    int           acc_edge = -100;
    int           acc_lat  = 0;
    logic [W-1:0] acc_res  = '0;
    logic         cmp_en   = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_edge <= -100;
            acc_lat  <= 0;
            acc_res  <= '0;
        end else begin
            edge_n <= edge_n + 1;
            if (start_i && (edge_n > acc_edge + acc_lat)) begin
                acc_edge <= edge_n;
                acc_lat  <= model_latency(op, b);
                acc_res  <= model_result(op, a, b);
            end
        end
    end

    always @(negedge clk) begin
        int last;
        bit exp_busy;
        bit exp_done;
        if (cmp_en) begin
            last     = edge_n - 1;
            exp_busy = (last >= acc_edge) && (last <= acc_edge + acc_lat - 1);
            exp_done = (acc_lat > 0) && (last == acc_edge + acc_lat - 1);
            check("cyc_busy", W'(busy), W'(exp_busy));
            check("cyc_done", W'(done), W'(exp_done));
            if (exp_done || !exp_busy) begin
                check("cyc_result", res, acc_res);
                check("cyc_zero", W'(zero), W'(acc_res == '0));
            end
        end
    end

    task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] exp_res, input int exp_lat);
        int  k;
        bit  seen;
        int  lat;
        lat = exp_lat;
`ifdef ALU_BARREL_SHIFT_EN
        if (o == 4'b0110 || o == 4'b0111) lat = 1;
`endif
        @(negedge clk);
        start_i = 1'b1;
        op      = o;
        a       = x;
        b       = y;
        @(negedge clk);
        start_i = 1'b0;
        k       = 1;
        seen    = 1'b0;
        while (k <= 100 && !seen) begin
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check({name, "_latency"}, seen ? W'(k) : '0, W'(lat));
        check({name, "_result"}, res, exp_res);
        check({name, "_zero"}, W'(zero), W'(exp_res == '0));
    endtask

    task automatic count_dones(input string name, input int cycles, input int exp_count);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        check(name, W'(n), W'(exp_count));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  seen;
        @(negedge clk);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_result", res, '0);
        check("rst_zero", W'(zero), 32'd1);
        cmp_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        run_op("add", 4'b0000, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1);

        // Reset asserted mid-cycle must clear outputs without a clock edge.
        #2 reset = 1'b1;
        #1;
        check("async_busy", W'(busy), '0);
        check("async_done", W'(done), '0);
        check("async_result", res, '0);
        check("async_zero", W'(zero), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        run_op("sub_neg", 4'b0001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1);
        run_op("sub_eq", 4'b0001, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1);
        run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
        run_op("or", 4'b0011, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1);
        run_op("sll31", 4'b0111, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32);
        run_op("srl_b24", 4'b0110, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 5);
        run_op("sll_zero_amt", 4'b0111, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1);
        run_op("srl33", 4'b0110, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 2);

        // Starts issued while busy must be ignored.
        @(negedge clk);
        start_i = 1'b1;
        op      = 4'b0110;
        a       = 32'hA5A5_0000;
        b       = 32'h0000_0008;
        @(negedge clk);
        op   = 4'b0000;
        a    = 32'h0000_0001;
        b    = 32'h0000_0001;
        k    = 1;
        seen = 1'b0;
        while (k <= 100 && !seen) begin
            if (done) seen = 1'b1;
            else begin
`ifndef ALU_BARREL_SHIFT_EN
                start_i = (k == 2);
`else
                start_i = 1'b0;
`endif
                @(negedge clk);
                k++;
            end
        end
`ifdef ALU_BARREL_SHIFT_EN
        check("busy_srl_latency", seen ? W'(k) : '0, 32'd1);
`else
        check("busy_srl_latency", seen ? W'(k) : '0, 32'd9);
`endif
        check("busy_srl_result", res, 32'h00A5_A500);
        run_op("b2b_add", 4'b0000, 32'h0000_0100, 32'h0000_0023, 32'h0000_0123, 1);
        count_dones("no_extra_done", 12, 0);

        // Reset during a 10-bit shift discards the operation.
        @(negedge clk);
        start_i = 1'b1;
        op      = 4'b0111;
        a       = 32'h0000_0001;
        b       = 32'h0000_000A;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("shift_rst_busy", W'(busy), '0);
        check("shift_rst_result", res, '0);
        @(negedge clk);
        reset = 1'b0;
        count_dones("shift_rst_no_done", 15, 0);
        check("shift_rst_hold", res, '0);

        run_op("unsupported_f", 4'b1111, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 1);
        run_op("lui", 4'b0101, 32'hFFFF_FFFF, 32'h1234_5000, 32'h1234_5000, 1);
        run_op("unsupported_2", 4'b0010, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
